led_counter_ctrl: RTL and testbench
===================================

LED_COUNTER_CTRL -- requirements
Module: led_counter_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, counter and LED width (1..16).
REQ-002 The block SHALL have parameter CLK_HZ, default 8000000, CLK frequency in Hz.
REQ-003 The block SHALL have parameter TICK_HZ, default 1, count-step rate in Hz; DIV = CLK_HZ/TICK_HZ, DIV >= 2.
REQ-004 The block SHALL have parameter DEBOUNCE_CYCLES, default 80000, stable cycles needed to accept a button change (>= 1).
REQ-005 The block SHALL have port CLK, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port RST, input, 1 bit, reset: synchronous, active-high.
REQ-007 The block SHALL have port BTN_MODE, input, 1 bit, asynchronous raw push-button; a press advances the mode.
REQ-008 The block SHALL have port BTN_CLEAR, input, 1 bit, asynchronous raw push-button; held = clear counter.
REQ-009 The block SHALL have port LED, output, WIDTH bits, current counter value.
REQ-010 The block SHALL have port MODE, output, 2 bits, current mode: 0 = UP, 1 = DOWN, 2 = HOLD.
REQ-011 The block SHALL have port TICK, output, 1 bit, one-CLK pulse at each step instant.

Function
REQ-012 The prescaler SHALL count 0..DIV-1 and wrap to 0; TICK SHALL be 1 exactly in cycles where prescaler == DIV-1, giving one pulse every DIV cycles.
REQ-013 Each button SHALL pass a 2-flop synchroniser, then a debouncer: the debounced state flips only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts the count.
REQ-014 Latency from a clean raw edge to the debounced change SHALL be 2 + DEBOUNCE_CYCLES cycles; pulses shorter than DEBOUNCE_CYCLES SHALL be ignored.
REQ-015 The mode FSM SHALL run UP -> DOWN -> HOLD -> UP, advancing once per debounced BTN_MODE rising edge; releasing the button and holding it SHALL not advance the mode; encoding 3 is unreachable and, if ever entered, SHALL go to UP next cycle.
REQ-016 In a TICK cycle the counter SHALL update, visible on LED the next cycle: UP +1 modulo 2^WIDTH (all-ones wraps to 0), DOWN -1 modulo 2^WIDTH (0 wraps to all-ones), HOLD unchanged.
REQ-017 A TICK in the same cycle as a mode advance SHALL use the mode held before the advance.
REQ-018 While debounced BTN_CLEAR = 1 the counter SHALL load 0 each cycle, overriding TICK; the prescaler and mode SHALL be unaffected.
REQ-019 LED and MODE SHALL be driven directly from registers, with no combinational path from any input.

Reset
REQ-020 When RST = 1 at a CLK edge: prescaler = 0, counter = 0 (LED = 0), MODE = UP, TICK = 0, synchronisers, debounced states and debounce counters = 0.
REQ-021 RST SHALL override every other input, including an asserted TICK or a button change; a button already held through reset SHALL register as a rising edge once it is debounced after reset.

Verification (WIDTH=4, CLK_HZ=4, TICK_HZ=1 so DIV=4, DEBOUNCE_CYCLES=3)
REQ-022 Release RST, buttons idle -> TICK pulses every 4th cycle; LED reads 1, 2, ... 15, 0 after successive ticks.
REQ-023 Press BTN_MODE for 10 cycles -> MODE = 1 exactly 5 cycles after the raw edge; later ticks step LED 0 -> 15 -> 14.
REQ-024 BTN_MODE glitch of 2 cycles -> MODE unchanged; two clean presses from DOWN -> HOLD, then UP; LED frozen while in HOLD.
REQ-025 Debounced BTN_CLEAR coincides with a TICK while LED = 7 -> LED = 0 next cycle and stays 0 while held; the TICK period is unchanged.
REQ-026 Assert RST for 1 cycle mid-count with LED = 9, MODE = DOWN -> next cycle LED = 0, MODE = 0, TICK = 0; the first TICK comes 4 cycles after reset is released.

Source files
------------

// File: rtl/led_counter_ctrl.sv
// LED up/down counter with a two-button user interface.
// A prescaler produces a step instant every DIV clocks. BTN_MODE cycles
// UP -> DOWN -> HOLD. Holding BTN_CLEAR keeps the counter at zero.
// Both buttons are synchronised and debounced before use.
module led_counter_ctrl #(
  parameter int WIDTH           = 4,
  parameter int CLK_HZ          = 8000000,
  parameter int TICK_HZ         = 1,
  parameter int DEBOUNCE_CYCLES = 80000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             BTN_MODE,
  input  logic             BTN_CLEAR,
  output logic [WIDTH-1:0] LED,
  output logic [1:0]       MODE,
  output logic             TICK
);

  // state     | meaning
  // MODE_UP   | counter increments on each tick
  // MODE_DOWN | counter decrements on each tick
  // MODE_HOLD | counter frozen
  // MODE_BAD  | unreachable encoding, recovers to MODE_UP
  typedef enum logic [1:0] {
    MODE_UP   = 2'd0,
    MODE_DOWN = 2'd1,
    MODE_HOLD = 2'd2,
    MODE_BAD  = 2'd3
  } mode_t;

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int DW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);

  // Button index 0 is BTN_MODE, index 1 is BTN_CLEAR.
  logic [1:0]    btn_raw;
  logic [1:0]    sync1_q, sync2_q, db_q, db_flip;
  logic [DW-1:0] db_cnt_q [2];
  logic [PW-1:0] presc_q;
  logic          tick;
  logic          mode_adv;
  logic [WIDTH-1:0] cnt_q;
  mode_t         mode_q, mode_d;

  assign btn_raw = {BTN_CLEAR, BTN_MODE};
  assign tick    = (presc_q == PRESC_LAST);

  // Free-running prescaler, 0..DIV-1.
  always_ff @(posedge CLK) begin
    if (RST)
      presc_q <= '0;
    else if (tick)
      presc_q <= '0;
    else
      presc_q <= presc_q + PW'(1);
  end

  // A debounced state flips on the edge where the disagreement count completes.
  always_comb begin
    db_flip = '0;
    for (int i = 0; i < 2; i++)
      db_flip[i] = (sync2_q[i] != db_q[i]) && (db_cnt_q[i] == DB_LAST);
  end

  // Advance on the flip itself so the mode changes with the debounced level.
  assign mode_adv = db_flip[0] && sync2_q[0];

  // Two-flop synchronisers and debounce counters for both buttons.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      for (int i = 0; i < 2; i++)
        db_cnt_q[i] <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_flip[i]) begin
          db_q[i]     <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  // Mode state register.
  always_ff @(posedge CLK) begin
    if (RST)
      mode_q <= MODE_UP;
    else
      mode_q <= mode_d;
  end

  // Mode next-state: one step per debounced press.
  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      MODE_UP:   if (mode_adv) mode_d = MODE_DOWN;
      MODE_DOWN: if (mode_adv) mode_d = MODE_HOLD;
      MODE_HOLD: if (mode_adv) mode_d = MODE_UP;
      default:   mode_d = MODE_UP;
    endcase
  end

  // Counter: clear wins over tick; a tick uses the mode held this cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (db_q[1]) begin
      cnt_q <= '0;
    end else if (tick) begin
      case (mode_q)
        MODE_UP:   cnt_q <= cnt_q + WIDTH'(1);
        MODE_DOWN: cnt_q <= cnt_q - WIDTH'(1);
        default:   cnt_q <= cnt_q;
      endcase
    end
  end

  assign LED  = cnt_q;
  assign MODE = mode_q;
  assign TICK = tick;

endmodule

// File: tb/tb_led_counter_ctrl.sv
// Directed bench for led_counter_ctrl with DIV=4 and DEBOUNCE_CYCLES=3.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_led_counter_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       BTN_MODE;
  logic       BTN_CLEAR;
  logic [3:0] LED;
  logic [1:0] MODE;
  logic       TICK;

  int checks = 0;
  int errors = 0;

  led_counter_ctrl #(
    .WIDTH(4), .CLK_HZ(4), .TICK_HZ(1), .DEBOUNCE_CYCLES(3)
  ) dut (
    .CLK(CLK), .RST(RST), .BTN_MODE(BTN_MODE), .BTN_CLEAR(BTN_CLEAR),
    .LED(LED), .MODE(MODE), .TICK(TICK)
  );

  always #5 CLK = ~CLK;

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RST = 1'b1; BTN_MODE = 1'b0; BTN_CLEAR = 1'b0;
    step(2);
    checks++; if (LED !== 4'd0) begin errors++; $display("FAIL reset_led got %0d want 0", LED); end
    checks++; if (MODE !== 2'd0) begin errors++; $display("FAIL reset_mode got %0d want 0", MODE); end
    checks++; if (TICK !== 1'b0) begin errors++; $display("FAIL reset_tick got %0b want 0", TICK); end
    RST = 1'b0;
  endtask

  // Sixteen ticks in UP: 1..15 then wrap to 0, one tick every 4 cycles.
  task automatic test_count_up;
    for (int i = 1; i <= 16; i++) begin
      step(2);
      checks++; if (TICK !== 1'b0) begin errors++; $display("FAIL up_tick_low[%0d] got %0b want 0", i, TICK); end
      step(1);
      checks++; if (TICK !== 1'b1) begin errors++; $display("FAIL up_tick_high[%0d] got %0b want 1", i, TICK); end
      step(1);
      checks++; if (LED !== 4'(i % 16)) begin errors++; $display("FAIL up_led[%0d] got %0d want %0d", i, LED, i % 16); end
    end
  endtask

  // 10-cycle press from LED=0, phase 0: one UP tick lands before the advance.
  task automatic test_mode_press;
    BTN_MODE = 1'b1;
    step(4);
    checks++; if (MODE !== 2'd0) begin errors++; $display("FAIL press_mode_early got %0d want 0", MODE); end
    checks++; if (LED !== 4'd1) begin errors++; $display("FAIL press_led_up got %0d want 1", LED); end
    step(1);
    checks++; if (MODE !== 2'd1) begin errors++; $display("FAIL press_mode_5 got %0d want 1", MODE); end
    step(5);
    BTN_MODE = 1'b0;
    checks++; if (LED !== 4'd0) begin errors++; $display("FAIL down_led0 got %0d want 0", LED); end
    step(2);
    checks++; if (LED !== 4'd15) begin errors++; $display("FAIL down_led15 got %0d want 15", LED); end
    step(4);
    checks++; if (LED !== 4'd14) begin errors++; $display("FAIL down_led14 got %0d want 14", LED); end
    checks++; if (MODE !== 2'd1) begin errors++; $display("FAIL release_no_adv got %0d want 1", MODE); end
  endtask

  task automatic test_glitch_and_hold;
    BTN_MODE = 1'b1;
    step(2);
    BTN_MODE = 1'b0;
    step(6);
    checks++; if (MODE !== 2'd1) begin errors++; $display("FAIL glitch_mode got %0d want 1", MODE); end
    checks++; if (LED !== 4'd12) begin errors++; $display("FAIL glitch_led got %0d want 12", LED); end
    BTN_MODE = 1'b1;
    step(5);
    checks++; if (MODE !== 2'd2) begin errors++; $display("FAIL hold_mode got %0d want 2", MODE); end
    checks++; if (LED !== 4'd11) begin errors++; $display("FAIL hold_entry_led got %0d want 11", LED); end
    step(3);
    BTN_MODE = 1'b0;
    step(8);
    checks++; if (LED !== 4'd11) begin errors++; $display("FAIL hold_frozen got %0d want 11", LED); end
    checks++; if (MODE !== 2'd2) begin errors++; $display("FAIL hold_stays got %0d want 2", MODE); end
    BTN_MODE = 1'b1;
    step(4);
    checks++; if (LED !== 4'd11) begin errors++; $display("FAIL hold_tick_old_mode got %0d want 11", LED); end
    step(1);
    checks++; if (MODE !== 2'd0) begin errors++; $display("FAIL hold_to_up got %0d want 0", MODE); end
    step(3);
    BTN_MODE = 1'b0;
    checks++; if (LED !== 4'd12) begin errors++; $display("FAIL up_again_led got %0d want 12", LED); end
    step(8);
    checks++; if (LED !== 4'd14) begin errors++; $display("FAIL up_again_led2 got %0d want 14", LED); end
  endtask

  // Debounced clear rises in the tick cycle where LED=7.
  task automatic test_clear;
    RST = 1'b1;
    step(1);
    RST = 1'b0;
    step(26);
    checks++; if (LED !== 4'd6) begin errors++; $display("FAIL clr_pre_led got %0d want 6", LED); end
    BTN_CLEAR = 1'b1;
    step(5);
    checks++; if (LED !== 4'd7) begin errors++; $display("FAIL clr_led7 got %0d want 7", LED); end
    checks++; if (TICK !== 1'b1) begin errors++; $display("FAIL clr_coincide_tick got %0b want 1", TICK); end
    step(1);
    checks++; if (LED !== 4'd0) begin errors++; $display("FAIL clr_over_tick got %0d want 0", LED); end
    step(3);
    checks++; if (TICK !== 1'b1) begin errors++; $display("FAIL clr_tick_period got %0b want 1", TICK); end
    step(1);
    checks++; if (LED !== 4'd0) begin errors++; $display("FAIL clr_held got %0d want 0", LED); end
    BTN_CLEAR = 1'b0;
    step(8);
    checks++; if (LED !== 4'd1) begin errors++; $display("FAIL clr_released got %0d want 1", LED); end
    checks++; if (MODE !== 2'd0) begin errors++; $display("FAIL clr_mode got %0d want 0", MODE); end
  endtask

  task automatic test_reset_mid;
    BTN_MODE = 1'b1;
    step(5);
    BTN_MODE = 1'b0;
    step(5);
    step(30);
    checks++; if (LED !== 4'd9) begin errors++; $display("FAIL mid_led9 got %0d want 9", LED); end
    checks++; if (MODE !== 2'd1) begin errors++; $display("FAIL mid_mode got %0d want 1", MODE); end
    step(1);
    RST = 1'b1;
    step(1);
    RST = 1'b0;
    checks++; if (LED !== 4'd0) begin errors++; $display("FAIL mid_rst_led got %0d want 0", LED); end
    checks++; if (MODE !== 2'd0) begin errors++; $display("FAIL mid_rst_mode got %0d want 0", MODE); end
    checks++; if (TICK !== 1'b0) begin errors++; $display("FAIL mid_rst_tick got %0b want 0", TICK); end
    step(2);
    checks++; if (TICK !== 1'b0) begin errors++; $display("FAIL mid_early_tick got %0b want 0", TICK); end
    step(1);
    checks++; if (TICK !== 1'b1) begin errors++; $display("FAIL mid_first_tick got %0b want 1", TICK); end
    step(1);
    checks++; if (LED !== 4'd1) begin errors++; $display("FAIL mid_first_step got %0d want 1", LED); end
  endtask

  // Button held through reset must advance once debounced afterwards.
  task automatic test_btn_through_reset;
    BTN_MODE = 1'b1;
    RST = 1'b1;
    step(3);
    checks++; if (MODE !== 2'd0) begin errors++; $display("FAIL thru_rst_mode got %0d want 0", MODE); end
    RST = 1'b0;
    step(4);
    checks++; if (MODE !== 2'd0) begin errors++; $display("FAIL thru_early got %0d want 0", MODE); end
    step(1);
    checks++; if (MODE !== 2'd1) begin errors++; $display("FAIL thru_adv got %0d want 1", MODE); end
    BTN_MODE = 1'b0;
    step(8);
    checks++; if (MODE !== 2'd1) begin errors++; $display("FAIL thru_release got %0d want 1", MODE); end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_mode_press();
    test_glitch_and_hold();
    test_clear();
    test_reset_mid();
    test_btn_through_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
